// File: rtl/sobel_linebuf_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_linebuf_ctrl
//   Streaming line-buffer controller for the Sobel pipeline. Pixels arrive one
//   per cycle in raster order. The two previous rows are kept in two
//   ram_1r1w_sync line memories. For every pixel of row 2 onward, a vertical
//   3-pixel column {row r-2, row r-1, row r} is emitted through a 3-entry
//   output FIFO. The FIFO hides the one-cycle RAM read latency behind a
//   valid/ready interface.
//
//   Ports
//     clk_i    : clock
//     rst_ni   : asynchronous active-low reset
//     valid_i  : input pixel valid
//     data_i   : input pixel [WIDTH_P-1:0]
//     ready_o  : pixel accepted when valid_i & ready_o
//     valid_o  : output column valid
//     data_o   : column {row r-2, row r-1, row r} [3*WIDTH_P-1:0]
//     eol_o    : set with the last column of a row
//     ready_i  : column consumed when valid_o & ready_i
//
//   ram_1r1w_sync (same file): one write port, one registered read port.
//   On a same-address read and write, the read returns the old contents.
// -----------------------------------------------------------------------------

module ram_1r1w_sync #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 640,
  parameter int ADDR_W  = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WIDTH_P-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [WIDTH_P-1:0] rd_data
);

  logic [WIDTH_P-1:0] mem [DEPTH_P];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

module sobel_linebuf_ctrl #(
  parameter int WIDTH_P      = 8,
  parameter int LINE_WIDTH_P = 640
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [WIDTH_P-1:0]   data_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [3*WIDTH_P-1:0] data_o,
  output logic                 eol_o,
  input  logic                 ready_i
);

  localparam int ADDR_W  = (LINE_WIDTH_P > 1) ? $clog2(LINE_WIDTH_P) : 1;
  localparam int COL_W   = 3 * WIDTH_P;
  localparam int ENTRY_W = COL_W + 1;
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WIDTH_P - 1);

  // Row counter saturates at 2: from then on every row has two rows above it.
  function automatic logic [1:0] rows_sat_inc(input logic [1:0] rows);
    return (rows == 2'd2) ? 2'd2 : rows + 2'd1;
  endfunction

  // FIFO pointers walk 0,1,2,0,...
  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  logic                accept;
  logic [ADDR_W-1:0]   col_r;
  logic [1:0]          rows_r;

  logic                vld_p1;
  logic [WIDTH_P-1:0]  pix_p1;
  logic [ADDR_W-1:0]   col_p1;
  logic                eol_p1;
  logic                emit_p1;
  logic [WIDTH_P-1:0]  r1_p1;
  logic [WIDTH_P-1:0]  r2_p1;

  logic [ENTRY_W-1:0]  fifo_mem [3];
  logic [1:0]          wr_ptr;
  logic [1:0]          rd_ptr;
  logic [1:0]          count;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  head;

  // ---------------------------------------------------------------------------
  // Stage 0: accept pixel, issue RAM reads at the current column
  // ---------------------------------------------------------------------------
  assign accept = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_r  <= '0;
      rows_r <= 2'd0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        if (col_r == LAST_COL) begin
          col_r  <= '0;
          rows_r <= rows_sat_inc(rows_r);
        end else begin
          col_r <= col_r + ADDR_W'(1);
        end
      end
    end
  end

  // Data side of the stage register; qualified by vld_p1, so no reset needed.
  // emit_p1 captures whether this row already has two rows stored above it,
  // which keeps stale RAM contents (after reset) from ever reaching data_o.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pix_p1  <= data_i;
      col_p1  <= col_r;
      eol_p1  <= (col_r == LAST_COL);
      emit_p1 <= (rows_r == 2'd2);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: RAM data available; shift rows down and form the column
  // ---------------------------------------------------------------------------
  // The stage-1 write to column c never meets the stage-0 read of column c+1,
  // so the RAM collision behaviour does not matter here.
  ram_1r1w_sync #(
    .WIDTH_P (WIDTH_P),
    .DEPTH_P (LINE_WIDTH_P),
    .ADDR_W  (ADDR_W)
  ) ram0 (
    .clk     (clk_i),
    .wr_en   (vld_p1),
    .wr_addr (col_p1),
    .wr_data (pix_p1),
    .rd_en   (accept),
    .rd_addr (col_r),
    .rd_data (r1_p1)
  );

  ram_1r1w_sync #(
    .WIDTH_P (WIDTH_P),
    .DEPTH_P (LINE_WIDTH_P),
    .ADDR_W  (ADDR_W)
  ) ram1 (
    .clk     (clk_i),
    .wr_en   (vld_p1),
    .wr_addr (col_p1),
    .wr_data (r1_p1),
    .rd_en   (accept),
    .rd_addr (col_r),
    .rd_data (r2_p1)
  );

  assign push = vld_p1 & emit_p1;

  // ---------------------------------------------------------------------------
  // Output FIFO: 3 entries of {eol, column}
  // ---------------------------------------------------------------------------
  assign valid_o = (count != 2'd0);
  assign pop     = valid_o & ready_i;
  assign head    = fifo_mem[rd_ptr];
  assign data_o  = valid_o ? head[COL_W-1:0] : '0;
  assign eol_o   = valid_o & head[COL_W];

  // A pixel in stage 1 has a FIFO slot reserved for it, so accepting only
  // while count + vld_p1 < 3 guarantees a push never finds the FIFO full.
  // Only registered state feeds this, so ready_i has no path to ready_o.
  assign ready_o = ({1'b0, count} + {2'b00, vld_p1}) < 3'd3;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= {eol_p1, r2_p1, r1_p1, pix_p1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_linebuf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_linebuf_ctrl
//   Bench for sobel_linebuf_ctrl with WIDTH_P=8, LINE_WIDTH_P=4. A negedge
//   monitor keeps a picture model: every accepted pixel is appended to a flat
//   image list, and for pixel index n in row 2 or later the expected column
//   is {img[n-2L], img[n-L], img[n]} with eol when n mod L == L-1. Popped
//   columns are compared in order against that expectation.
// -----------------------------------------------------------------------------

module tb_sobel_linebuf_ctrl;

  localparam int W = 8;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic           valid_i;
  logic [W-1:0]   data_i;
  logic           ready_o;
  logic           valid_o;
  logic [3*W-1:0] data_o;
  logic           eol_o;
  logic           ready_i;

  sobel_linebuf_ctrl #(
    .WIDTH_P      (W),
    .LINE_WIDTH_P (L)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .eol_o   (eol_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [W-1:0]     img   [$];
  logic [3*W:0]     exp_q [$];
  logic [3*W:0]     got_q [$];
  int               pop_cyc [$];
  int               cyc = 0;
  int               nrdy_low;
  int               first_vld_cyc;
  int               acc2l_cyc;
  bit               prev_stall;
  logic [3*W:0]     prev_word;
  logic [W-1:0]     src [64];

  task automatic model_clear();
    img.delete();
    exp_q.delete();
    got_q.delete();
    pop_cyc.delete();
    nrdy_low      = 0;
    first_vld_cyc = -1;
    acc2l_cyc     = -1;
    prev_stall    = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", valid_o, 1);
        check_eq("hold_data", {eol_o, data_o}, prev_word);
      end
      if (valid_o && exp_q.size() == 0)
        check_eq("spurious_valid", valid_o, 0);
      if (valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (!ready_o) nrdy_low++;
      if (valid_o && ready_i) begin
        if (exp_q.size() != 0) check_eq("column", {eol_o, data_o}, exp_q.pop_front());
        got_q.push_back({eol_o, data_o});
        pop_cyc.push_back(cyc);
      end
      if (valid_i && ready_o) begin
        int n;
        n = img.size();
        img.push_back(data_i);
        if (n == 2 * L) acc2l_cyc = cyc;
        if (n >= 2 * L)
          exp_q.push_back({(n % L == L - 1), img[n - 2 * L], img[n - L], data_i});
      end
      prev_stall = valid_o && !ready_i;
      prev_word  = {eol_o, data_o};
    end
  end

  task automatic do_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  // Presents src[k0..k1-1] with random valid/ready gaps; starts and ends
  // one time unit after a rising edge.
  task automatic stream(input int k0, input int k1, input int vpct, input int rpct,
                        input int max_cyc, input bit must_finish, output int k_out);
    int k;
    int c;
    k = k0;
    c = 0;
    while (k < k1 && c < max_cyc) begin
      valid_i = ($urandom_range(99) < vpct);
      data_i  = src[k];
      ready_i = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (valid_i && ready_o) k++;
      @(posedge clk);
      #1;
      c++;
    end
    valid_i = 1'b0;
    if (must_finish) check_eq("stream_done", k, k1);
    k_out = k;
  endtask

  task automatic drain();
    int c;
    valid_i = 1'b0;
    ready_i = 1'b1;
    c = 0;
    while ((exp_q.size() != 0 || valid_o) && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    model_clear();
    #2;
    check_eq("rst_ready_o", ready_o, 1);
    check_eq("rst_valid_o", valid_o, 0);
    check_eq("rst_eol_o",   eol_o,   0);
    check_eq("rst_data_o",  data_o,  0);

    // Fill and first output
    do_reset();
    for (int i = 0; i < 64; i++) src[i] = W'(i);
    stream(0, 12, 100, 100, 200, 1'b1, k);
    drain();
    check_eq("fill_ncols", got_q.size(), 4);
    check_eq("fill_latency", first_vld_cyc - acc2l_cyc, 2);
    if (got_q.size() == 4) begin
      check_eq("fill_col0", got_q[0], {1'b0, 8'h00, 8'h04, 8'h08});
      check_eq("fill_col3", got_q[3], {1'b1, 8'h03, 8'h07, 8'h0B});
    end

    // Throughput: five continuous rows
    do_reset();
    stream(0, 20, 100, 100, 20, 1'b1, k);
    drain();
    check_eq("thru_ready_low", nrdy_low, 0);
    check_eq("thru_ncols", got_q.size(), 12);
    if (got_q.size() == 12) begin
      check_eq("thru_consecutive", pop_cyc[11] - pop_cyc[0], 11);
      check_eq("thru_row3_col0", got_q[4], {1'b0, 8'h04, 8'h08, 8'h0C});
    end

    // Backpressure from the start of row 2
    do_reset();
    stream(0, 8, 100, 100, 50, 1'b1, k);
    stream(k, 16, 100, 0, 8, 1'b0, k);
    check_eq("bp_accepted", k, 11);
    check_eq("bp_ready_o", ready_o, 0);
    check_eq("bp_valid_o", valid_o, 1);
    check_eq("bp_data_o", {eol_o, data_o}, {1'b0, 8'h00, 8'h04, 8'h08});
    stream(k, 16, 100, 100, 100, 1'b1, k);
    drain();
    check_eq("bp_ncols", got_q.size(), 8);

    // Bubbles with random pixel data over six rows
    do_reset();
    for (int i = 0; i < 24; i++) src[i] = W'($urandom);
    stream(0, 24, 60, 60, 2000, 1'b1, k);
    drain();
    check_eq("bub_ncols", got_q.size(), 16);

    // Reset in the middle of row 2
    do_reset();
    for (int i = 0; i < 64; i++) src[i] = W'(i);
    stream(0, 10, 100, 0, 100, 1'b1, k);
    check_eq("mid_valid_before", valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_valid_o", valid_o, 0);
    check_eq("mid_rst_ready_o", ready_o, 1);
    check_eq("mid_rst_data_o",  data_o,  0);
    do_reset();
    for (int i = 0; i < 12; i++) src[i] = W'(8'h20 + i);
    stream(0, 12, 100, 100, 200, 1'b1, k);
    drain();
    check_eq("mid_ncols", got_q.size(), 4);
    if (got_q.size() != 0)
      check_eq("mid_first_col", got_q[0], {1'b0, 8'h20, 8'h24, 8'h28});

    // Wrap-around into a new row
    do_reset();
    for (int i = 0; i < 16; i++) src[i] = W'(i);
    src[16] = 8'h10; src[17] = 8'h11; src[18] = 8'h12; src[19] = 8'hFF;
    for (int i = 20; i < 24; i++) src[i] = W'(8'h30 + i - 20);
    stream(0, 24, 80, 80, 500, 1'b1, k);
    drain();
    check_eq("wrap_ncols", got_q.size(), 16);
    if (got_q.size() == 16) begin
      check_eq("wrap_last",  got_q[11], {1'b1, 8'h0B, 8'h0F, 8'hFF});
      check_eq("wrap_next",  got_q[12], {1'b0, 8'h0C, 8'h10, 8'h30});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
